// File: rtl/soc_multi_timer_if.sv
// rtl/soc_multi_timer_if.sv - register bus shared by the multi-channel timer and its bus master
interface soc_multi_timer_if;
  logic [4:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/soc_multi_timer.sv
// rtl/soc_multi_timer.sv - NUM_CH independent prescaled down-counters with snapshot and interrupts
module soc_multi_timer #(
  parameter int NUM_CH       = 2,
  parameter int CNT_W        = 32,
  parameter int RESET_PERIOD = 49999
) (
  input  logic                clk,
  input  logic                reset_n,
  soc_multi_timer_if.slave    bus,
  output logic                irq,
  output logic [NUM_CH-1:0]   irq_vec,
  output logic [NUM_CH-1:0]   timeout_pulse
);

  localparam logic [4:0]       IRQ_ADDR = 5'd28;
  localparam logic [CNT_W-1:0] RST_VAL  = CNT_W'(RESET_PERIOD);

  logic        wr;
  logic [2:0]  ch_sel;
  logic [1:0]  word_sel;
  logic [31:0] rd_next;
  logic [31:0] ch_rdata [NUM_CH];

  assign wr       = bus.chipselect & ~bus.write_n;
  assign ch_sel   = bus.address[4:2];
  assign word_sel = bus.address[1:0];

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] period_q;
    logic [CNT_W-1:0] snap_q;
    logic [7:0]       pcnt_q;
    logic [7:0]       prescale_q;
    logic             ito_q;
    logic             cont_q;
    logic             run_q;
    logic             to_q;
    logic             pulse_q;
    logic             sel;
    logic             wr_status;
    logic             wr_ctrl;
    logic             wr_period;
    logic             wr_snap;
    logic             start;
    logic             stop;
    logic             tick;
    logic             expire;
    logic [31:0]      rdata;

    assign sel       = wr && (ch_sel == 3'(g));
    assign wr_status = sel && (word_sel == 2'd0);
    assign wr_ctrl   = sel && (word_sel == 2'd1);
    assign wr_period = sel && (word_sel == 2'd2);
    assign wr_snap   = sel && (word_sel == 2'd3);
    assign start     = wr_ctrl && bus.writedata[2];
    assign stop      = wr_ctrl && bus.writedata[3];
    assign tick      = run_q && (pcnt_q == prescale_q);
    assign expire    = tick && (count_q == '0);

    // Later assignments in this block deliberately override earlier ones:
    // a PERIOD write beats the tick, STOP beats START, a timeout beats a TO clear.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        count_q    <= RST_VAL;
        period_q   <= RST_VAL;
        snap_q     <= '0;
        pcnt_q     <= 8'd0;
        prescale_q <= 8'd0;
        ito_q      <= 1'b0;
        cont_q     <= 1'b0;
        run_q      <= 1'b0;
        to_q       <= 1'b0;
        pulse_q    <= 1'b0;
      end else begin
        if (run_q) begin
          pcnt_q <= tick ? 8'd0 : pcnt_q + 8'd1;
        end
        if (tick) begin
          count_q <= (count_q == '0) ? period_q : count_q - CNT_W'(1);
        end
        if (expire && !cont_q) begin
          run_q <= 1'b0;
        end
        to_q    <= expire | (to_q & ~wr_status);
        pulse_q <= expire;

        if (wr_ctrl) begin
          ito_q      <= bus.writedata[0];
          cont_q     <= bus.writedata[1];
          prescale_q <= bus.writedata[11:4];
        end
        if (stop) begin
          run_q <= 1'b0;
        end else if (start) begin
          run_q <= 1'b1;
        end

        if (wr_period) begin
          period_q <= bus.writedata[CNT_W-1:0];
          count_q  <= bus.writedata[CNT_W-1:0];
          pcnt_q   <= 8'd0;
          run_q    <= 1'b0;
        end
        // Non-blocking read of count_q gives the value before this edge's decrement.
        if (wr_snap) begin
          snap_q <= count_q;
        end
      end
    end

    always_comb begin
      rdata = '0;
      case (word_sel)
        2'd0:    rdata[1:0]       = {run_q, to_q};
        2'd1:    rdata[11:0]      = {prescale_q, 2'b00, cont_q, ito_q};
        2'd2:    rdata[CNT_W-1:0] = period_q;
        default: rdata[CNT_W-1:0] = snap_q;
      endcase
    end

    assign ch_rdata[g]      = rdata;
    assign irq_vec[g]       = to_q & ito_q;
    assign timeout_pulse[g] = pulse_q;
  end

  assign irq = |irq_vec;

  // Word 28 decodes as channel 7, which never exists, so the loop cannot alias it.
  always_comb begin
    rd_next = '0;
    if (bus.address == IRQ_ADDR) begin
      rd_next[NUM_CH-1:0] = irq_vec;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (ch_sel == 3'(c)) begin
          rd_next = ch_rdata[c];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.readdata <= '0;
    end else begin
      bus.readdata <= rd_next;
    end
  end

endmodule
